// File: rtl/eq4_bist.sv
// eq4_bist: walks all 256 {X,Y} operand pairs into an eq4 under test and counts Z mismatches; start-to-done takes 1 + 256*(SETTLE+1) cycles.
// start is ignored while busy. Optional first-fail capture of X/Y is enabled by macro EQ4_BIST_FIRST_FAIL_EN.
module eq4_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_x,
  output logic [3:0] fail_y
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [7:0] idx;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic [7:0] err_nxt;
  logic       launch;

  // X/Y come straight from the registered vector index, so they are glitch-free.
  assign {X, Y}   = idx;
  assign mismatch = (Z != (X == Y));
  assign err_nxt  = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
  assign launch   = (state == IDLE || state == DONE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 8'h00;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            idx        <= 8'h00;
            settle_cnt <= 4'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'h00;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= SAMPLE;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          err_count <= err_nxt;
          if (idx == 8'hFF) begin
            // idx stays at FF, which parks X/Y at 4'hF while done.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 8'h00);
          end else begin
            idx   <= idx + 8'd1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EQ4_BIST_FIRST_FAIL_EN
  // err_count is still zero only up to the first mismatch of a pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_x <= 4'h0;
      fail_y <= 4'h0;
    end else if (launch) begin
      fail_x <= 4'h0;
      fail_y <= 4'h0;
    end else if (state == SAMPLE && mismatch && err_count == 8'h00) begin
      fail_x <= X;
      fail_y <= Y;
    end
  end
`else
  assign fail_x = 4'h0;
  assign fail_y = 4'h0;
  logic unused_launch;
  assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_eq4_bist.sv
// Bench for eq4_bist: arithmetic pass model checked every cycle on two instances (SETTLE=1 and 3), plus literal expectations.
module tb_eq4_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  int   mode1 = 0, mode3 = 0;
  int   cyc = 0;
  int   tests = 0, fails = 0;
  bit   chk_on = 1'b0;

  logic [3:0] x1, y1, fx1, fy1, x3, y3, fx3, fy3;
  logic       z1, z3, busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0] err1, err3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eq4_bist #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .X(x1), .Y(y1), .Z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_x(fx1), .fail_y(fy1));

  eq4_bist #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .X(x3), .Y(y3), .Z(z3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_x(fx3), .fail_y(fy3));

  // eq4 behaviours: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 wrong only at X=8,Y=1
  function automatic logic zf(input int mode, input logic [3:0] x, input logic [3:0] y);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (x == 4'h8 && y == 4'h1) ? 1'b1 : (x == y);
      default: return (x == y);
    endcase
  endfunction

  always_comb z1 = zf(mode1, x1, y1);
  always_comb z3 = zf(mode3, x3, y3);

  function automatic bit mm(input int mode, input int j);
    logic [3:0] x, y;
    x = 4'(j >> 4);
    y = 4'(j);
    return zf(mode, x, y) != (x == y);
  endfunction

  typedef struct packed {
    logic [3:0] x, y;
    logic       busy, done, pass;
    logic [7:0] err;
    logic [3:0] fx, fy;
  } exp_t;

  // n = clock edges since the edge that accepted start
  function automatic exp_t model(input int s, input int mode, input bit run, input int n);
    exp_t e;
    int lim, k, cnt, first;
    e = '0;
    if (!run) return e;
    lim = 256 * (s + 1);
    k = (n >= lim) ? 256 : n / (s + 1);
    cnt = 0;
    first = -1;
    for (int j = 0; j < k; j++)
      if (mm(mode, j)) begin
        cnt++;
        if (first < 0) first = j;
      end
    e.err = (cnt > 255) ? 8'hFF : 8'(cnt);
    if (n >= lim) begin
      e.x = 4'hF; e.y = 4'hF; e.done = 1'b1; e.pass = (cnt == 0);
    end else begin
      e.x = 4'((n / (s + 1)) >> 4); e.y = 4'(n / (s + 1)); e.busy = 1'b1;
    end
`ifdef EQ4_BIST_FIRST_FAIL_EN
    if (first >= 0) begin
      e.fx = 4'(first >> 4); e.fy = 4'(first);
    end
`endif
    return e;
  endfunction

  bit run1 = 0, run3 = 0;
  int n1 = 0, n3 = 0, pm1 = 0, pm3 = 0;
  localparam int L1 = 512, L3 = 1024;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run1 <= 0; n1 <= 0; run3 <= 0; n3 <= 0;
    end else begin
      if ((!run1 || n1 >= L1) && start1) begin
        run1 <= 1; n1 <= 0; pm1 <= mode1;
      end else if (run1 && n1 < L1) n1 <= n1 + 1;
      if ((!run3 || n3 >= L3) && start3) begin
        run3 <= 1; n3 <= 0; pm3 <= mode3;
      end else if (run3 && n3 < L3) n3 <= n3 + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [3:0] x, input logic [3:0] y,
                     input logic b, input logic d, input logic p, input logic [7:0] er,
                     input logic [3:0] fx, input logic [3:0] fy);
    chk({tag, ".X"}, 32'(x), 32'(e.x));
    chk({tag, ".Y"}, 32'(y), 32'(e.y));
    chk({tag, ".busy"}, 32'(b), 32'(e.busy));
    chk({tag, ".done"}, 32'(d), 32'(e.done));
    chk({tag, ".pass"}, 32'(p), 32'(e.pass));
    chk({tag, ".err_count"}, 32'(er), 32'(e.err));
    chk({tag, ".fail_x"}, 32'(fx), 32'(e.fx));
    chk({tag, ".fail_y"}, 32'(fy), 32'(e.fy));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("s1", model(1, pm1, run1, n1), x1, y1, busy1, done1, pass1, err1, fx1, fy1);
      cmp("s3", model(3, pm3, run3, n3), x3, y3, busy3, done3, pass3, err3, fx3, fy3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SETTLE=1 pass; optional stray start pulse at loop cycle glitch_at.
  task automatic run1_pass(input int mode, input int glitch_at, output int lat);
    int c0;
    mode1 = mode;
    tick();
    start1 = 1'b1;
    c0 = cyc;
    tick();
    start1 = 1'b0;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (glitch_at > 0 && i == glitch_at) start1 = 1'b1;
      if (glitch_at > 0 && i == glitch_at + 1) start1 = 1'b0;
      if (done1) begin
        lat = cyc - c0;
        break;
      end
    end
    if (lat < 0) chk("timeout_done1", 32'd0, 32'd1);
  endtask

  int lat;
  int c0;

  initial begin
    repeat (3) tick();
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle.busy", 32'(busy1), 32'd0);
    chk("idle.X", 32'(x1), 32'd0);

    run1_pass(0, 0, lat);
    chk("good.latency", lat, 513);
    chk("good.pass", 32'(pass1), 32'd1);
    chk("good.err", 32'(err1), 32'd0);

    run1_pass(1, 0, lat);
    chk("stuck0.err", 32'(err1), 32'd16);
    chk("stuck0.pass", 32'(pass1), 32'd0);
    chk("stuck0.fail_x", 32'(fx1), 32'd0);
    chk("stuck0.fail_y", 32'(fy1), 32'd0);

    run1_pass(2, 0, lat);
    chk("stuck1.err", 32'(err1), 32'd240);
    chk("stuck1.pass", 32'(pass1), 32'd0);
    chk("stuck1.fail_x", 32'(fx1), 32'd0);
`ifdef EQ4_BIST_FIRST_FAIL_EN
    chk("stuck1.fail_y", 32'(fy1), 32'd1);
`else
    chk("stuck1.fail_y", 32'(fy1), 32'd0);
`endif

    run1_pass(3, 50, lat);
    chk("single.latency", lat, 513);
    chk("single.err", 32'(err1), 32'd1);
`ifdef EQ4_BIST_FIRST_FAIL_EN
    chk("single.fail_x", 32'(fx1), 32'd8);
    chk("single.fail_y", 32'(fy1), 32'd1);
`else
    chk("single.fail_x", 32'(fx1), 32'd0);
    chk("single.fail_y", 32'(fy1), 32'd0);
`endif

    // Abort a pass with reset at cycle 100, then rerun.
    mode1 = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.busy", 32'(busy1), 32'd0);
    chk("rst.X", 32'(x1), 32'd0);
    chk("rst.Y", 32'(y1), 32'd0);
    chk("rst.err", 32'(err1), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst.busy", 32'(busy1), 32'd0);
    chk("post_rst.done", 32'(done1), 32'd0);
    run1_pass(1, 0, lat);
    chk("rerun.latency", lat, 513);
    chk("rerun.err", 32'(err1), 32'd16);

    // SETTLE=3 with start held high throughout.
    mode3 = 0;
    tick();
    start3 = 1'b1;
    c0 = cyc;
    lat = -1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (done3) begin
        lat = cyc - c0;
        break;
      end
    end
    if (lat < 0) chk("timeout_done3", 32'd0, 32'd1);
    chk("hold.latency", lat, 1025);
    chk("hold.pass", 32'(pass3), 32'd1);
    @(negedge clk);
    chk("hold.done_drop", 32'(done3), 32'd0);
    chk("hold.busy_again", 32'(busy3), 32'd1);
    start3 = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
